// File: rtl/freq_m_pkg.sv
// Shared types and helpers for the multi-channel frequency meter.
// No logic; constants and a gate-length helper only.
// No flow control.
package freq_m_pkg;

    // Gate FSM: waiting for enable, or counting inside a gate
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default gate lengths in reference-clock cycles
    localparam int unsigned BASE0_DEF = 400_000_000;
    localparam int unsigned BASE1_DEF = 100_000_000;

    // Width of the gate-shortening shift and the guard bits it can push out
    localparam int DEL_W   = 3;
    localparam int EXT_W   = 7;
    localparam int MAX_DEL = 7;

    // Gate length in cycles for a given base and shortening shift
    function automatic int unsigned gate_len(input int unsigned base, input logic [DEL_W-1:0] del);
        return base >> del;
    endfunction

endpackage

// File: rtl/freq_m_chan.sv
// One measurement channel: synchronise, edge-detect, count edges, scale result.
// Latency: pin to count SYNC_N+1 cycles; result is combinational from the live count.
// No backpressure: the result is only meaningful while gate_end is high.
// Build option FREQ_M_MULTI_SAT_EN: saturate the result to all-ones on overflow.
module freq_m_chan
    import freq_m_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int SYNC_N = 2
) (
    input  logic             clk_base,
    input  logic             reset,
    input  logic             run,
    input  logic             gate_end,
    input  logic [DEL_W-1:0] shift,
    input  logic             pin,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    logic [SYNC_N-1:0]      sync;
    logic                   prev;
    logic                   edge_det;
    logic [CNT_W-1:0]       cnt;
    logic                   wrap;
    logic [CNT_W:0]         sum;
    logic [CNT_W+EXT_W-1:0] scaled;

    // Bring the asynchronous pin into clk_base and keep one older sample
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_N-2:0], pin};
            prev <= sync[SYNC_N-1];
        end
    end

    assign edge_det = sync[SYNC_N-1] & ~prev;
    assign sum      = {1'b0, cnt} + {{CNT_W{1'b0}}, edge_det};

    // Count edges inside a gate; remember any wrap until the gate closes
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (!run || gate_end) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= sum[CNT_W-1:0];
            wrap <= wrap | sum[CNT_W];
        end
    end

    // Scale the final count (including this cycle's edge) and flag overflow
    always_comb begin
        scaled = {{EXT_W{1'b0}}, sum[CNT_W-1:0]} << shift;
        ovf    = wrap | sum[CNT_W] | (|scaled[CNT_W+EXT_W-1:CNT_W]);
`ifdef FREQ_M_MULTI_SAT_EN
        result = ovf ? {CNT_W{1'b1}} : scaled[CNT_W-1:0];
`else
        result = scaled[CNT_W-1:0];
`endif
    end

endmodule

// File: rtl/freq_m_multi.sv
// Multi-channel frequency meter: N_CH gated edge counters sharing one gate timer.
// Latency: result registered one cycle after the last gate cycle, with a 1-cycle res_valid.
// No backpressure: results are strobed out; build option FREQ_M_MULTI_SAT_EN saturates on overflow.
module freq_m_multi
    import freq_m_pkg::*;
#(
    parameter int          N_CH   = 4,
    parameter int          CNT_W  = 32,
    parameter int unsigned BASE0  = BASE0_DEF,
    parameter int unsigned BASE1  = BASE1_DEF,
    parameter int          SYNC_N = 2
) (
    input  logic                  clk_base,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_CH-1:0]       clk_in,
    input  logic                  freq_base_sel,
    input  logic [DEL_W-1:0]      time_del,
    output logic [N_CH*CNT_W-1:0] freq_mem,
    output logic                  res_valid,
    output logic [N_CH-1:0]       ovf,
    output logic                  gate_act
);

    localparam int GW = $clog2(BASE0);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("freq_m_multi: N_CH must be 1..16");
    end
    if (SYNC_N < 2) begin : g_bad_sync
        $error("freq_m_multi: SYNC_N must be at least 2");
    end
    if (gate_len(BASE0, 3'(MAX_DEL)) < 2 || gate_len(BASE1, 3'(MAX_DEL)) < 2) begin : g_bad_gate
        $error("freq_m_multi: shortest gate must be at least 2 cycles");
    end
    // The gate counter is sized from BASE0, so BASE1 must not be longer
    if (BASE1 > BASE0) begin : g_bad_base
        $error("freq_m_multi: BASE1 must not exceed BASE0");
    end

    state_t                state;
    logic [GW-1:0]         gate_cnt;
    logic [GW-1:0]         g_last;
    logic                  sel_sh;
    logic [DEL_W-1:0]      del_sh;
    logic                  run;
    logic                  gate_end;
    logic [N_CH*CNT_W-1:0] chan_res;
    logic [N_CH-1:0]       chan_ovf;

    // Last gate cycle index for the configuration latched at the gate start
    always_comb begin
        g_last = GW'(gate_len(sel_sh ? BASE1 : BASE0, del_sh) - 32'd1);
    end

    assign run      = (state == RUN);
    assign gate_end = run && (gate_cnt == g_last);

    // Gate FSM: open on enable, restart back-to-back at each boundary, abort on disable
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gate_cnt <= '0;
            sel_sh   <= 1'b0;
            del_sh   <= '0;
            gate_act <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    if (en) begin
                        state    <= RUN;
                        gate_act <= 1'b1;
                        sel_sh   <= freq_base_sel;
                        del_sh   <= time_del;
                    end
                end
                RUN: begin
                    if (gate_end) begin
                        gate_cnt <= '0;
                        sel_sh   <= freq_base_sel;
                        del_sh   <= time_del;
                        if (!en) begin
                            state    <= IDLE;
                            gate_act <= 1'b0;
                        end
                    end else if (!en) begin
                        state    <= IDLE;
                        gate_act <= 1'b0;
                        gate_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gate_act <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        freq_m_chan #(
            .CNT_W  (CNT_W),
            .SYNC_N (SYNC_N)
        ) u_chan (
            .clk_base (clk_base),
            .reset    (reset),
            .run      (run),
            .gate_end (gate_end),
            .shift    (del_sh),
            .pin      (clk_in[c]),
            .result   (chan_res[c*CNT_W +: CNT_W]),
            .ovf      (chan_ovf[c])
        );
    end

    // Publish all channels together one cycle after the gate closes
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            freq_mem  <= '0;
            ovf       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= gate_end;
            if (gate_end) begin
                freq_mem <= chan_res;
                ovf      <= chan_ovf;
            end
        end
    end

endmodule
